// File: rtl/pipe_ctrl_pkg.sv
// Shared constants and types for the pipeline hazard/stall controller.
package pipe_ctrl_pkg;

  // Decode-stage operand mux selects
  localparam logic [1:0] FWD_RF   = 2'd0;
  localparam logic [1:0] FWD_EALU = 2'd1;
  localparam logic [1:0] FWD_MALU = 2'd2;
  localparam logic [1:0] FWD_MMEM = 2'd3;

  // Memory-wait sequencer states
  typedef enum logic [1:0] {
    RUN   = 2'd0,
    MWAIT = 2'd1,
    HALT  = 2'd2
  } state_e;

  // A writing stage matches a source only when its destination is not r0
  function automatic logic reg_hit(input logic wr, input logic [4:0] rn,
                                   input logic [4:0] src);
    return wr && (rn != 5'd0) && (rn == src);
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Pipeline <-> hazard controller signal bundle. The controller is the slave.
interface pipe_hazard_ctrl_if;
  logic [4:0]  rs, rt;
  logic        d_users, d_usert;
  logic        ewreg, em2reg;
  logic [4:0]  ern;
  logic        mwreg, mm2reg, mwmem;
  logic [4:0]  mrn;
  logic        dmem_ack;
  logic [1:0]  fwda, fwdb;
  logic        wpcir, dbubble, pipe_hold, mwbubble, dmem_req, mem_err;
  logic [31:0] luse_cnt, mwait_cnt;

  modport slave (
    input  rs, rt, d_users, d_usert, ewreg, em2reg, ern,
           mwreg, mm2reg, mwmem, mrn, dmem_ack,
    output fwda, fwdb, wpcir, dbubble, pipe_hold, mwbubble, dmem_req,
           mem_err, luse_cnt, mwait_cnt
  );

  modport master (
    output rs, rt, d_users, d_usert, ewreg, em2reg, ern,
           mwreg, mm2reg, mwmem, mrn, dmem_ack,
    input  fwda, fwdb, wpcir, dbubble, pipe_hold, mwbubble, dmem_req,
           mem_err, luse_cnt, mwait_cnt
  );
endinterface

// File: rtl/pipe_fwd_sel.sv
// Per-source forwarding select and load-use detect (purely combinational).
module pipe_fwd_sel
  import pipe_ctrl_pkg::*;
(
  input  logic [4:0] src_i,
  input  logic       use_i,
  input  logic       ewreg_i,
  input  logic       em2reg_i,
  input  logic [4:0] ern_i,
  input  logic       mwreg_i,
  input  logic       mm2reg_i,
  input  logic [4:0] mrn_i,
  output logic [1:0] sel_o,
  output logic       luse_o
);
  logic e_hit, m_hit;

  assign e_hit = reg_hit(ewreg_i, ern_i, src_i);
  assign m_hit = reg_hit(mwreg_i, mrn_i, src_i);

  // A load in E cannot forward yet; that case stalls instead. E beats M.
  always_comb begin
    sel_o = FWD_RF;
    if (e_hit && !em2reg_i) sel_o = FWD_EALU;
    else if (m_hit)         sel_o = mm2reg_i ? FWD_MMEM : FWD_MALU;
  end

  // Select is produced regardless of use; the stall only counts real reads
  assign luse_o = e_hit && em2reg_i && use_i;
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/stall controller: forwarding, load-use interlock, memory-wait
// sequencer with sticky timeout. Optional perf counters: PIPE_PERF_CNT_EN.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int WAIT_MAX = 16
) (
  input  logic         clock,
  input  logic         resetn,
  pipe_hazard_ctrl_if.slave hz
);
  localparam logic [7:0] WLAST = 8'(WAIT_MAX - 1);

  state_e     state_q, state_d;
  logic [7:0] wcnt_q, wcnt_d;
  logic       mem_err_q, mem_err_d;
  logic       luse_a, luse_b, luse, m_access, hold;

  pipe_fwd_sel u_fwd_a (
    .src_i(hz.rs), .use_i(hz.d_users), .ewreg_i(hz.ewreg), .em2reg_i(hz.em2reg),
    .ern_i(hz.ern), .mwreg_i(hz.mwreg), .mm2reg_i(hz.mm2reg), .mrn_i(hz.mrn),
    .sel_o(hz.fwda), .luse_o(luse_a)
  );

  pipe_fwd_sel u_fwd_b (
    .src_i(hz.rt), .use_i(hz.d_usert), .ewreg_i(hz.ewreg), .em2reg_i(hz.em2reg),
    .ern_i(hz.ern), .mwreg_i(hz.mwreg), .mm2reg_i(hz.mm2reg), .mrn_i(hz.mrn),
    .sel_o(hz.fwdb), .luse_o(luse_b)
  );

  assign luse     = luse_a | luse_b;
  assign m_access = hz.mwmem | hz.mm2reg;
  assign hold     = (m_access && !hz.dmem_ack) || (state_q == HALT);

  // Hold freezes everything, so the interlock waits until release
  assign hz.pipe_hold = hold;
  assign hz.mwbubble  = hold;
  assign hz.wpcir     = !hold && !luse;
  assign hz.dbubble   = !hold && luse;
  assign hz.dmem_req  = m_access && (state_q != HALT);
  assign hz.mem_err   = mem_err_q;

  // Sequencer state, wait counter and sticky error
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q   <= RUN;
      wcnt_q    <= '0;
      mem_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wcnt_q    <= wcnt_d;
      mem_err_q <= mem_err_d;
    end
  end

  // Next state: ack beats timeout on the last wait cycle
  always_comb begin
    state_d   = state_q;
    wcnt_d    = wcnt_q;
    mem_err_d = mem_err_q;
    unique case (state_q)
      RUN: if (m_access && !hz.dmem_ack) begin
        state_d = MWAIT;
        wcnt_d  = '0;
      end
      MWAIT: begin
        wcnt_d = wcnt_q + 8'd1;
        if (hz.dmem_ack) state_d = RUN;
        else if (wcnt_q == WLAST) begin
          state_d   = HALT;
          mem_err_d = 1'b1;
        end
      end
      HALT:    state_d = HALT;
      default: state_d = RUN;
    endcase
  end

`ifdef PIPE_PERF_CNT_EN
  logic [31:0] luse_cnt_q, mwait_cnt_q;

  // Saturating counts of bubble cycles and hold cycles
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      luse_cnt_q  <= '0;
      mwait_cnt_q <= '0;
    end else begin
      if (hz.dbubble && (luse_cnt_q != '1)) luse_cnt_q  <= luse_cnt_q + 32'd1;
      if (hold && (mwait_cnt_q != '1))      mwait_cnt_q <= mwait_cnt_q + 32'd1;
    end
  end

  assign hz.luse_cnt  = luse_cnt_q;
  assign hz.mwait_cnt = mwait_cnt_q;
`else
  assign hz.luse_cnt  = '0;
  assign hz.mwait_cnt = '0;
`endif
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl (WAIT_MAX=4).
module tb_pipe_hazard_ctrl;
  import pipe_ctrl_pkg::*;

`ifdef PIPE_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic clock, resetn;
  int   total = 0;
  int   bad   = 0;

  pipe_hazard_ctrl_if hz();

  pipe_hazard_ctrl #(.WAIT_MAX(4)) dut (
    .clock(clock), .resetn(resetn), .hz(hz)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clock);
  endtask

  task automatic clr();
    hz.rs = 0; hz.rt = 0; hz.d_users = 0; hz.d_usert = 0;
    hz.ewreg = 0; hz.em2reg = 0; hz.ern = 0;
    hz.mwreg = 0; hz.mm2reg = 0; hz.mwmem = 0; hz.mrn = 0; hz.dmem_ack = 0;
  endtask

  function automatic logic [31:0] pc(input int n);
    return PERF ? 32'(n) : 32'd0;
  endfunction

  initial begin
    clr();
    resetn = 1'b0;
    #1;
    chk("rst_fwda", 32'(hz.fwda), 0);
    chk("rst_fwdb", 32'(hz.fwdb), 0);
    chk("rst_wpcir", 32'(hz.wpcir), 1);
    chk("rst_dbubble", 32'(hz.dbubble), 0);
    chk("rst_hold", 32'(hz.pipe_hold), 0);
    chk("rst_mwbubble", 32'(hz.mwbubble), 0);
    chk("rst_dmem_req", 32'(hz.dmem_req), 0);
    chk("rst_mem_err", 32'(hz.mem_err), 0);
    chk("rst_luse_cnt", hz.luse_cnt, 0);
    chk("rst_mwait_cnt", hz.mwait_cnt, 0);
    tick(); resetn = 1'b1;

    // E beats M
    hz.ern = 5; hz.ewreg = 1; hz.rs = 5; hz.d_users = 1; hz.mrn = 5; hz.mwreg = 1;
    #1 chk("fwd_e_beats_m", 32'(hz.fwda), 1);
    chk("fwd_e_wpcir", 32'(hz.wpcir), 1);
    tick();
    // M load forward, unused rt still selected, zero-wait access
    hz.ewreg = 0; hz.mm2reg = 1; hz.dmem_ack = 1; hz.rt = 5; hz.d_usert = 0;
    #1 chk("fwd_m_mem_a", 32'(hz.fwda), 3);
    chk("fwd_m_mem_b_unused", 32'(hz.fwdb), 3);
    chk("zero_wait_hold", 32'(hz.pipe_hold), 0);
    chk("zero_wait_req", 32'(hz.dmem_req), 1);
    tick();
    // r0 never matches
    clr(); hz.ewreg = 1; hz.mwreg = 1; hz.d_users = 1; hz.d_usert = 1;
    #1 chk("fwd_r0_a", 32'(hz.fwda), 0);
    chk("fwd_r0_b", 32'(hz.fwdb), 0);
    hz.em2reg = 1;
    #1 chk("luse_r0", 32'(hz.dbubble), 0);
    tick();
    // M ALU forward
    clr(); hz.mwreg = 1; hz.mrn = 9; hz.rs = 9; hz.rt = 9; hz.ern = 9;
    #1 chk("fwd_m_alu_a", 32'(hz.fwda), 2);
    chk("fwd_m_alu_b", 32'(hz.fwdb), 2);
    tick();

    // Load-use on rt
    clr(); hz.ewreg = 1; hz.em2reg = 1; hz.ern = 8; hz.rt = 8; hz.rs = 3; hz.d_users = 1;
    #1 chk("luse_unused_rt", 32'(hz.dbubble), 0);
    hz.d_usert = 1;
    #1 chk("luse_wpcir", 32'(hz.wpcir), 0);
    chk("luse_dbubble", 32'(hz.dbubble), 1);
    chk("luse_fwdb_e_load", 32'(hz.fwdb), 0);
    chk("luse_hold", 32'(hz.pipe_hold), 0);
    tick();
    clr(); hz.mwreg = 1; hz.mm2reg = 1; hz.mrn = 8; hz.rt = 8; hz.d_usert = 1; hz.dmem_ack = 1;
    #1 chk("luse_after_wpcir", 32'(hz.wpcir), 1);
    chk("luse_after_dbubble", 32'(hz.dbubble), 0);
    chk("luse_after_fwdb", 32'(hz.fwdb), 3);
    chk("luse_cnt_1", hz.luse_cnt, pc(1));
    tick();

    // Store waiting three cycles
    clr(); hz.mwmem = 1;
    for (int i = 0; i < 3; i++) begin
      #1 chk("mw_hold", 32'(hz.pipe_hold), 1);
      chk("mw_mwbubble", 32'(hz.mwbubble), 1);
      chk("mw_req", 32'(hz.dmem_req), 1);
      chk("mw_wpcir", 32'(hz.wpcir), 0);
      tick();
    end
    hz.dmem_ack = 1;
    #1 chk("mw_ack_hold", 32'(hz.pipe_hold), 0);
    chk("mw_ack_req", 32'(hz.dmem_req), 1);
    chk("mw_ack_wpcir", 32'(hz.wpcir), 1);
    tick();
    clr();
    #1 chk("mw_done_hold", 32'(hz.pipe_hold), 0);
    chk("mw_done_req", 32'(hz.dmem_req), 0);
    chk("mw_done_state", 32'(dut.state_q), 32'(RUN));
    chk("mwait_cnt_3", hz.mwait_cnt, pc(3));

    // Hold overrides load-use; bubble appears on release
    hz.mwmem = 1; hz.ewreg = 1; hz.em2reg = 1; hz.ern = 8; hz.rt = 8; hz.d_usert = 1;
    #1 chk("hl_dbubble", 32'(hz.dbubble), 0);
    chk("hl_wpcir", 32'(hz.wpcir), 0);
    chk("hl_hold", 32'(hz.pipe_hold), 1);
    tick();
    hz.dmem_ack = 1;
    #1 chk("hl_rel_hold", 32'(hz.pipe_hold), 0);
    chk("hl_rel_dbubble", 32'(hz.dbubble), 1);
    chk("hl_rel_wpcir", 32'(hz.wpcir), 0);
    tick();
    clr();
    #1 chk("luse_cnt_2", hz.luse_cnt, pc(2));
    chk("mwait_cnt_4", hz.mwait_cnt, pc(4));

    // Ack on the last allowed wait cycle wins over timeout
    hz.mwmem = 1;
    for (int i = 0; i < 4; i++) begin
      #1 chk("lim_hold", 32'(hz.pipe_hold), 1);
      tick();
    end
    hz.dmem_ack = 1;
    #1 chk("lim_ack_hold", 32'(hz.pipe_hold), 0);
    tick();
    clr();
    #1 chk("lim_mem_err", 32'(hz.mem_err), 0);
    chk("lim_hold_after", 32'(hz.pipe_hold), 0);
    chk("mwait_cnt_8", hz.mwait_cnt, pc(8));

    // Timeout: RUN cycle + 4 MWAIT cycles, then HALT
    hz.mwmem = 1;
    for (int i = 0; i < 5; i++) begin
      #1 chk("to_hold", 32'(hz.pipe_hold), 1);
      chk("to_mem_err_pre", 32'(hz.mem_err), 0);
      tick();
    end
    #1 chk("to_mem_err", 32'(hz.mem_err), 1);
    chk("to_halt_hold", 32'(hz.pipe_hold), 1);
    chk("to_halt_req", 32'(hz.dmem_req), 0);
    hz.mwmem = 0;
    #1 chk("to_halt_hold_idle", 32'(hz.pipe_hold), 1);
    chk("to_halt_mwbubble", 32'(hz.mwbubble), 1);
    chk("to_halt_wpcir", 32'(hz.wpcir), 0);
    tick(); tick();
    #1 chk("to_sticky_err", 32'(hz.mem_err), 1);
    chk("to_sticky_hold", 32'(hz.pipe_hold), 1);

    // Async reset out of HALT
    resetn = 1'b0;
    #1 chk("rst_halt_hold", 32'(hz.pipe_hold), 0);
    chk("rst_halt_mem_err", 32'(hz.mem_err), 0);
    chk("rst_halt_wpcir", 32'(hz.wpcir), 1);
    chk("rst_halt_mwait_cnt", hz.mwait_cnt, 0);
    tick(); resetn = 1'b1;

    // Async reset out of MWAIT
    hz.mwmem = 1;
    tick(); tick();
    #1 chk("pre_rst_state", 32'(dut.state_q), 32'(MWAIT));
    hz.mwmem = 0; resetn = 1'b0;
    #1 chk("rst_mwait_state", 32'(dut.state_q), 32'(RUN));
    chk("rst_mwait_mem_err", 32'(hz.mem_err), 0);
    chk("rst_mwait_req", 32'(hz.dmem_req), 0);
    tick(); resetn = 1'b1;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
